// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and opcode encodings for the execute-stage ALU.
//   DATA_W - operand/result width
//   IMM_W  - immediate width
//   SA_W   - shift amount width
//   OP_*   - 4-bit operation select values; 1011..1111 are reserved
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 14;
  localparam int SA_W   = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_CMP  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLR  = 4'b0101;
  localparam logic [3:0] OP_SLLV = 4'b0110;
  localparam logic [3:0] OP_SLRV = 4'b0111;
  localparam logic [3:0] OP_ANDI = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath of the ALU.
//   ALUop    in  4   operation select
//   rs1      in  32  operand A
//   rs2      in  32  operand B
//   imm      in  14  immediate
//   SA       in  5   constant shift amount
//   res      out 32  next result
//   carry    out 1   next carry/borrow/shift-out
//   overflow out 1   next signed overflow
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]        ALUop,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [IMM_W-1:0]  imm,
  input  logic [SA_W-1:0]   SA,
  output logic [DATA_W-1:0] res,
  output logic              carry,
  output logic              overflow
);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic [SA_W-1:0]   sh_amt;
  logic              sh_left;
  logic [DATA_W:0]   shl;
  logic [DATA_W:0]   shr;

  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};

  // One adder serves ADD and ADDI; bit 32 is the unsigned carry-out.
  assign add_b   = (ALUop == OP_ADDI) ? imm_sext : rs2;
  assign sum     = {1'b0, rs1} + {1'b0, add_b};
  assign add_ovf = (rs1[DATA_W-1] == add_b[DATA_W-1]) &&
                   (sum[DATA_W-1] != rs1[DATA_W-1]);

  // Bit 32 of the 33-bit difference is the unsigned borrow.
  assign diff    = {1'b0, rs1} - {1'b0, rs2};
  assign sub_ovf = (rs1[DATA_W-1] != rs2[DATA_W-1]) &&
                   (diff[DATA_W-1] != rs1[DATA_W-1]);

  // Shared shifter. Each direction carries one guard bit so the last bit
  // shifted out lands in it; a zero amount leaves the guard at 0.
  assign sh_amt  = (ALUop == OP_SLL || ALUop == OP_SLR) ? SA : rs2[SA_W-1:0];
  assign sh_left = (ALUop == OP_SLL || ALUop == OP_SLLV);
  assign shl     = {1'b0, rs1} << sh_amt;
  assign shr     = {rs1, 1'b0} >> sh_amt;

  always_comb begin
    res      = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (ALUop)
      OP_AND:  res = rs1 & rs2;
      OP_OR:   res = rs1 | rs2;
      OP_ANDI: res = rs1 & imm_zext;
      OP_ADD, OP_ADDI: begin
        res      = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        overflow = add_ovf;
      end
      OP_SUB: begin
        res      = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
        overflow = sub_ovf;
      end
      OP_CMP: begin
        // Signed ordering taken from the subtractor: less-than is N xor V.
        if (diff[DATA_W-1:0] == '0)
          res = '0;
        else if (diff[DATA_W-1] ^ sub_ovf)
          res = '1;
        else
          res = {{(DATA_W-1){1'b0}}, 1'b1};
        carry    = diff[DATA_W];
        overflow = sub_ovf;
      end
      OP_SLL, OP_SLLV, OP_SLR, OP_SLRV: begin
        if (sh_left) begin
          res   = shl[DATA_W-1:0];
          carry = shl[DATA_W];
        end else begin
          res   = shr[DATA_W:1];
          carry = shr[0];
        end
      end
      default: begin
        res      = '0;
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: registered 32-bit ALU for the execute stage, one op per cycle.
//   clk      in  1   rising-edge clock
//   reset    in  1   synchronous active-high; clears all outputs
//   ALUop    in  4   operation select
//   rs1      in  32  operand A
//   rs2      in  32  operand B
//   imm      in  14  immediate
//   SA       in  5   constant shift amount
//   result   out 32  registered result
//   zero     out 1   registered, set when result is all zeros
//   carry    out 1   registered carry/borrow/shift-out
//   overflow out 1   registered signed overflow
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        ALUop,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [IMM_W-1:0]  imm,
  input  logic [SA_W-1:0]   SA,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              overflow
);

  logic [DATA_W-1:0] res_d;
  logic              carry_d;
  logic              ovf_d;

  alu_core u_core (
    .ALUop    (ALUop),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .SA       (SA),
    .res      (res_d),
    .carry    (carry_d),
    .overflow (ovf_d)
  );

  // Reset clears zero as well, even though result is 0 at that point.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      result   <= res_d;
      zero     <= (res_d == '0);
      carry    <= carry_d;
      overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ALUop;
  logic [31:0] rs1, rs2;
  logic [13:0] imm;
  logic [4:0]  SA;
  logic [31:0] result;
  logic        zero, carry, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [13:0] i;
    logic [4:0]  sa;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  always #5 clk = ~clk;

  alu dut (
    .clk      (clk),
    .reset    (reset),
    .ALUop    (ALUop),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .SA       (SA),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  // Drive on the falling edge, sample 1 ns after the following rising edge.
  task automatic apply(input logic rst, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [13:0] i, input logic [4:0] sa);
    @(negedge clk);
    reset = rst; ALUop = op; rs1 = a; rs2 = b; imm = i; SA = sa;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, OP_SLL, 32'd4, 32'd0, 14'd0, 5'd5);
    apply(1'b1, OP_SLL, 32'd4, 32'd0, 14'd0, 5'd5);
    checks++;
    if ({result, zero, carry, overflow} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got r=%h z=%b c=%b v=%b want r=0 z=0 c=0 v=0",
               result, zero, carry, overflow);
    end
    apply(1'b0, OP_SLL, 32'd4, 32'd0, 14'd0, 5'd5);
    checks++;
    if ({result, zero, carry, overflow} !== {32'd128, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got r=%h z=%b c=%b v=%b want r=80 z=0 c=0 v=0",
               result, zero, carry, overflow);
    end
  endtask

  task automatic test_arith();
    vec_t t[$];
    t.push_back('{"add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'd1, 14'd0, 5'd0, 32'h80000000, 1'b0, 1'b0, 1'b1});
    t.push_back('{"add_carry", OP_ADD, 32'hFFFFFFFF, 32'd1, 14'd0, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0});
    t.push_back('{"sub_eq",    OP_SUB, 32'd5, 32'd5, 14'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0});
    t.push_back('{"sub_borrow",OP_SUB, 32'd2, 32'd3, 14'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
    t.push_back('{"sub_ovf",   OP_SUB, 32'h80000000, 32'd1, 14'd0, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1});
    t.push_back('{"cmp_lt",    OP_CMP, 32'hFFFFFFFF, 32'd1, 14'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
    t.push_back('{"cmp_gt",    OP_CMP, 32'd1, 32'hFFFFFFFF, 14'd0, 5'd0, 32'h00000001, 1'b0, 1'b1, 1'b0});
    t.push_back('{"cmp_eq",    OP_CMP, 32'h12345678, 32'h12345678, 14'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0});
    t.push_back('{"cmp_ovf",   OP_CMP, 32'h7FFFFFFF, 32'h80000000, 14'd0, 5'd0, 32'h00000001, 1'b0, 1'b1, 1'b1});
    t.push_back('{"addi_neg",  OP_ADDI, 32'd10, 32'hDEAD, 14'h3FFF, 5'd0, 32'd9, 1'b0, 1'b1, 1'b0});
    t.push_back('{"addi_pos",  OP_ADDI, 32'd10, 32'd0, 14'h1000, 5'd0, 32'h0000100A, 1'b0, 1'b0, 1'b0});
    foreach (t[k]) begin
      apply(1'b0, t[k].op, t[k].a, t[k].b, t[k].i, t[k].sa);
      checks++;
      if ({result, zero, carry, overflow} !== {t[k].res, t[k].z, t[k].c, t[k].v}) begin
        errors++;
        $display("FAIL %s: got r=%h z=%b c=%b v=%b want r=%h z=%b c=%b v=%b", t[k].name,
                 result, zero, carry, overflow, t[k].res, t[k].z, t[k].c, t[k].v);
      end
    end
  endtask

  task automatic test_logic_shift();
    vec_t t[$];
    t.push_back('{"and",       OP_AND, 32'hF0F0FF00, 32'h0FF0F0F0, 14'd0, 5'd0, 32'h00F0F000, 1'b0, 1'b0, 1'b0});
    t.push_back('{"or",        OP_OR,  32'hF0000000, 32'h0000000F, 14'd0, 5'd0, 32'hF000000F, 1'b0, 1'b0, 1'b0});
    t.push_back('{"andi",      OP_ANDI, 32'hFFFFFFFF, 32'd0, 14'h3FFF, 5'd0, 32'h00003FFF, 1'b0, 1'b0, 1'b0});
    t.push_back('{"sll_out",   OP_SLL, 32'h80000001, 32'd0, 14'd0, 5'd1, 32'h00000002, 1'b0, 1'b1, 1'b0});
    t.push_back('{"sll_zero",  OP_SLL, 32'h80000000, 32'd0, 14'd0, 5'd0, 32'h80000000, 1'b0, 1'b0, 1'b0});
    t.push_back('{"slr_sa4",   OP_SLR, 32'h0000001F, 32'd3, 14'd0, 5'd4, 32'h00000001, 1'b0, 1'b1, 1'b0});
    t.push_back('{"slrv",      OP_SLRV, 32'h80000001, 32'd1, 14'd0, 5'd7, 32'h40000000, 1'b0, 1'b1, 1'b0});
    t.push_back('{"sllv_mask", OP_SLLV, 32'd3, 32'h00000021, 14'd0, 5'd9, 32'd6, 1'b0, 1'b0, 1'b0});
    t.push_back('{"sllv_31",   OP_SLLV, 32'h00000003, 32'd31, 14'd0, 5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0});
    t.push_back('{"reserved",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h3FFF, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0});
    t.push_back('{"reserved_b",4'b1011, 32'h7FFFFFFF, 32'd1, 14'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
    foreach (t[k]) begin
      apply(1'b0, t[k].op, t[k].a, t[k].b, t[k].i, t[k].sa);
      checks++;
      if ({result, zero, carry, overflow} !== {t[k].res, t[k].z, t[k].c, t[k].v}) begin
        errors++;
        $display("FAIL %s: got r=%h z=%b c=%b v=%b want r=%h z=%b c=%b v=%b", t[k].name,
                 result, zero, carry, overflow, t[k].res, t[k].z, t[k].c, t[k].v);
      end
    end
  endtask

  task automatic test_hold_and_midreset();
    apply(1'b0, OP_ADD, 32'd100, 32'd23, 14'd0, 5'd0);
    // Change inputs between edges; outputs must not move before the next edge.
    ALUop = OP_SUB; rs1 = 32'd1; rs2 = 32'd2;
    #2;
    checks++;
    if ({result, zero, carry, overflow} !== {32'd123, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold: got r=%h z=%b c=%b v=%b want r=7b z=0 c=0 v=0",
               result, zero, carry, overflow);
    end
    // Reset overrides a pending ADD that would otherwise produce a carry.
    apply(1'b1, OP_ADD, 32'hFFFFFFFF, 32'd2, 14'd0, 5'd0);
    checks++;
    if ({result, zero, carry, overflow} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset: got r=%h z=%b c=%b v=%b want r=0 z=0 c=0 v=0",
               result, zero, carry, overflow);
    end
    apply(1'b0, OP_ADD, 32'hFFFFFFFF, 32'd2, 14'd0, 5'd0);
    checks++;
    if ({result, zero, carry, overflow} !== {32'd1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset: got r=%h z=%b c=%b v=%b want r=1 z=0 c=1 v=0",
               result, zero, carry, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int n = 0; n < 8; n++) begin
      apply(1'b0, OP_ADD, 32'd1000 * n, 32'd7 + n, 14'd0, 5'd0);
      exp = 32'd1000 * n + 32'd7 + n;
      checks++;
      if (result !== exp || zero !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: got r=%h z=%b want r=%h z=0", n, result, zero, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; ALUop = 4'd0; rs1 = '0; rs2 = '0; imm = '0; SA = '0;
    test_reset();
    test_arith();
    test_logic_shift();
    test_hold_and_midreset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit integer ALU for the simple RISC processor's execute stage. It selects one of eleven operations via a 4-bit opcode over two register operands, a 14-bit immediate and a 5-bit shift amount. It registers a 32-bit result and zero/carry/overflow flags on each rising clock edge.

## Interface
- No parameters; data width fixed at 32, immediate 14, shift amount 5.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all outputs
- ALUop  input  4  operation select
- rs1  input  32  operand A
- rs2  input  32  operand B
- imm  input  14  immediate operand
- SA  input  5  constant shift amount
- result  output  32  registered result
- zero  output  1  registered, 1 when the next result is all zeros
- carry  output  1  registered carry/borrow/shift-out
- overflow  output  1  registered signed overflow

## Operation
- Opcode map:
  - 0000 AND: rs1 & rs2
  - 0001 ADD: rs1 + rs2
  - 0010 SUB: rs1 - rs2
  - 0011 CMP: signed compare; result 32'h00000001 if rs1 > rs2, 32'hFFFFFFFF if rs1 < rs2, 0 if equal
  - 0100 SLL: rs1 << SA
  - 0101 SLR: rs1 >> SA, logical
  - 0110 SLLV: rs1 << rs2[4:0]
  - 0111 SLRV: rs1 >> rs2[4:0], logical
  - 1000 ANDI: rs1 & zero-extended imm
  - 1001 ADDI: rs1 + sign-extended imm (also load/store address)
  - 1010 OR: rs1 | rs2
  - 1011–1111: reserved; result 0, carry 0, overflow 0, zero 1
- Sign extension replicates imm[13] into bits 31:14. Zero extension fills bits 31:14 with zeros.
- carry:
  - ADD/ADDI: bit 32 of the 33-bit unsigned sum.
  - SUB/CMP: borrow, 1 iff rs1 < rs2 unsigned.
  - Shifts: last bit shifted out; 0 when the shift amount is 0.
  - Logic ops: 0.
- overflow:
  - ADD/ADDI: operands share a sign and the sum sign differs.
  - SUB/CMP: operand signs differ and the difference sign differs from rs1.
  - All other ops: 0.
- zero is computed from the final result value, so for CMP it refers to the ±1/0 encoding.
- Inputs have no handshake; they are sampled every cycle.

## Timing
- All four outputs are registered; latency is one cycle.
- Inputs present before rising edge N appear on the outputs after edge N.
- With reset=1 at a rising edge, the outputs become result=0, zero=0, carry=0, overflow=0. Reset overrides ALUop.
- Asserting reset mid-stream discards the pending computation. The first post-reset result appears at the first edge with reset=0.
- Outputs hold between edges. Input glitches between edges have no effect.
- Throughput: one new operation per cycle, back-to-back, with no stall.

## Structure
- Package alu_pkg: localparams for the eleven opcodes, plus data/immediate/shift widths.
- Sub-module alu_core: purely combinational. It takes the opcode and operands and produces the next result, carry and overflow. The top level computes zero and owns the synchronous-reset output register.
- Shifts are implemented with one shared shifter: amount is SA or rs2[4:0], direction is left or right.

## Test plan
- Reset held at rs1=4, SA=5, ALUop=0100 → all outputs 0. Release reset → after the next edge, result=128, zero=0, carry=0, overflow=0.
- ADD rs1=32'h7FFFFFFF, rs2=1 → result 32'h80000000, overflow=1, carry=0. ADD rs1=32'hFFFFFFFF, rs2=1 → result 0, zero=1, carry=1, overflow=0.
- SUB rs1=5, rs2=5 → result 0, zero=1, carry=0. SUB rs1=2, rs2=3 → result 32'hFFFFFFFF, carry=1.
- ADDI rs1=10, imm=14'h3FFF → result 9. ANDI rs1=32'hFFFFFFFF, imm=14'h3FFF → result 32'h00003FFF.
- SLRV rs1=32'h80000001, rs2=1 → result 32'h40000000, carry=1. SLLV with rs2=32'h00000021 uses amount 1 → rs1=3 gives 6.
- CMP rs1=-1, rs2=1 → 32'hFFFFFFFF. CMP rs1=1, rs2=-1 → 1. Equal operands → 0 with zero=1. Reserved opcode 1111 → result 0, zero=1.
